// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // x is the XOR of all data bits and the received parity bit.
  // Odd framing wants that XOR to be 1, even framing wants it to be 0.
  function automatic logic parity_bad(input int mode, input logic x);
    return (mode == PAR_ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/rx_sync_edge.sv
// Two-flop synchronizer for the serial pin plus a history flop for
// start-edge detection. The edge pulse is registered, which puts the
// pin-to-bps_start latency at four clock edges.
module rx_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic sync1;
  logic sync2;
  logic hist;

  // Synchronizer chain, history flop and registered falling-edge pulse.
  // All flops reset to the idle line level so reset itself is never an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 1'b1;
      fall  <= 1'b0;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
      hist  <= sync2;
      fall  <= hist & ~sync2;
    end
  end

  assign rx_s = sync2;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: runs the external baud generator through
// bps_start, samples the line on each bps_clk strobe and reports bytes.
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | line idle, waiting for a start edge, generator stopped
// ST_START  | generator running, waiting for mid-start-bit strobe
// ST_DATA   | shifting in data bits, LSB first
// ST_PARITY | capturing the parity bit (only when PARITY != 0)
// ST_STOP   | sampling the stop bit and issuing the result pulse
// ST_BREAK  | stop bit was 0; wait for the line to return high
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int PARITY    = 0,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 bps_clk,
  output logic                 bps_start,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_t            state;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 rx_s;
  logic                 fall;

  rx_sync_edge u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (fall)
  );

  // Frame sequencer; all outputs registered, result flags default low
  // every cycle so each one is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      bps_start  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A strobe landing with the edge is stale; only fall matters here.
          if (fall) begin
            state     <= ST_START;
            bps_start <= 1'b1;
          end
        end
        ST_START: begin
          if (bps_clk) begin
            if (rx_s) begin
              state     <= ST_IDLE;
              bps_start <= 1'b0;
            end else begin
              state   <= ST_DATA;
              bit_cnt <= '0;
              par_bad <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (bps_clk) begin
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT)
              state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (bps_clk) begin
            par_bad <= parity_bad(PARITY, (^shreg) ^ rx_s);
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bps_clk) begin
            bps_start <= 1'b0;
            if (rx_s) begin
              state <= ST_IDLE;
              if (par_bad) begin
                parity_err <= 1'b1;
              end else begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end
            end else begin
              state      <= ST_BREAK;
              frame_err  <= 1'b1;
              parity_err <= par_bad;
            end
          end
        end
        ST_BREAK: begin
          // Holding here keeps a stuck-low line from looking like a new start.
          bps_start <= 1'b0;
          if (rx_s)
            state <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          bps_start <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: two instances (no parity, even parity) each
// driven by a behavioural 115200-baud generator at a 50 MHz clock.
module tb_uart_rx_ctrl;

  localparam int BIT_CYC = 434;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] rx  = 2'b11;
  logic [1:0] bps_clk;
  wire  [1:0] bps_start;
  wire  [1:0] rx_valid;
  wire  [1:0] frame_err;
  wire  [1:0] parity_err;
  wire  [1:0] busy;
  wire  [7:0] rx_data0;
  wire  [7:0] rx_data1;

  always #10 clk = ~clk;

  uart_rx_ctrl #(.PARITY(0), .DATA_BITS(8)) u_dut0 (
    .clk(clk), .rst(rst), .rx(rx[0]), .bps_clk(bps_clk[0]),
    .bps_start(bps_start[0]), .rx_data(rx_data0), .rx_valid(rx_valid[0]),
    .frame_err(frame_err[0]), .parity_err(parity_err[0]), .busy(busy[0])
  );

  uart_rx_ctrl #(.PARITY(2), .DATA_BITS(8)) u_dut1 (
    .clk(clk), .rst(rst), .rx(rx[1]), .bps_clk(bps_clk[1]),
    .bps_start(bps_start[1]), .rx_data(rx_data1), .rx_valid(rx_valid[1]),
    .frame_err(frame_err[1]), .parity_err(parity_err[1]), .busy(busy[1])
  );

  // Baud generator model: divider 433, strobe at count 216, held at 0 when stopped.
  logic [8:0] bcnt [2];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst || !bps_start[i]) bcnt[i] <= '0;
      else bcnt[i] <= (bcnt[i] == 9'd433) ? 9'd0 : bcnt[i] + 9'd1;
    end
  end
  always_comb begin
    bps_clk = '0;
    for (int i = 0; i < 2; i++) bps_clk[i] = bps_start[i] && (bcnt[i] == 9'd216);
  end

  // Monitor: counts pulses and strobes, timestamps bps_start edges.
  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int n_valid[2]  = '{0, 0};
  int n_ferr[2]   = '{0, 0};
  int n_perr[2]   = '{0, 0};
  int n_strobe[2] = '{0, 0};
  int n_rise[2]   = '{0, 0};
  int last_strobe[2] = '{0, 0};
  int rise_cyc[2] = '{0, 0};
  int fall_cyc[2] = '{0, 0};
  int fall_age[2] = '{0, 0};
  int n_wide = 0;
  int q_cyc[$];
  logic [7:0] q_data[$];
  logic [1:0] p_start = '0, p_v = '0, p_f = '0, p_p = '0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (bps_clk[i]) begin n_strobe[i]++; last_strobe[i] = cyc; end
        if (!p_start[i] && bps_start[i]) begin n_rise[i]++; rise_cyc[i] = cyc; end
        if (p_start[i] && !bps_start[i]) begin
          fall_cyc[i] = cyc;
          fall_age[i] = cyc - last_strobe[i];
        end
        if (rx_valid[i]) begin
          n_valid[i]++;
          if (i == 0) begin q_cyc.push_back(cyc); q_data.push_back(rx_data0); end
        end
        if (frame_err[i])  n_ferr[i]++;
        if (parity_err[i]) n_perr[i]++;
        if ((rx_valid[i] && p_v[i]) || (frame_err[i] && p_f[i]) || (parity_err[i] && p_p[i]))
          n_wide++;
      end
      p_start = bps_start; p_v = rx_valid; p_f = frame_err; p_p = parity_err;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int rdata(input int i);
    return (i == 0) ? int'(rx_data0) : int'(rx_data1);
  endfunction

  task automatic bit_time(input int i, input logic v);
    @(negedge clk);
    rx[i] = v;
    repeat (BIT_CYC - 1) @(negedge clk);
  endtask

  // Start bit, 8 data bits LSB first, parity on instance 1, stop bit.
  // Leaves the line at the stop-bit level.
  task automatic send_frame(input int i, input logic [7:0] d, input logic p, input logic stop);
    bit_time(i, 1'b0);
    for (int b = 0; b < 8; b++) bit_time(i, d[b]);
    if (i == 1) bit_time(i, p);
    bit_time(i, stop);
  endtask

  typedef struct {
    int         inst;
    logic [7:0] d;
    logic       p;
    logic       stop;
    int         ev;
    int         ef;
    int         ep;
    logic [7:0] ed;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int sv, sf, sp, ss, sr, lat, k, q0, dur;
    tbl[0] = '{0, 8'hA5, 1'b0, 1'b1, 1, 0, 0, 8'hA5};
    tbl[1] = '{0, 8'h00, 1'b0, 1'b1, 1, 0, 0, 8'h00};
    tbl[2] = '{0, 8'hFF, 1'b0, 1'b1, 1, 0, 0, 8'hFF};
    tbl[3] = '{0, 8'h81, 1'b0, 1'b1, 1, 0, 0, 8'h81};
    tbl[4] = '{0, 8'h5A, 1'b0, 1'b0, 0, 1, 0, 8'h81};
    tbl[5] = '{1, 8'h07, 1'b1, 1'b1, 1, 0, 0, 8'h07};
    tbl[6] = '{1, 8'h07, 1'b0, 1'b1, 0, 0, 1, 8'h07};
    tbl[7] = '{1, 8'h03, 1'b1, 1'b0, 0, 1, 1, 8'h07};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_bps_start", int'(bps_start[i]), 0);
      check("rst_busy", int'(busy[i]), 0);
      check("rst_rx_data", rdata(i), 0);
      check("rst_flags", int'(rx_valid[i] | frame_err[i] | parity_err[i]), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Table-driven frames
    for (int t = 0; t < 8; t++) begin
      int i;
      i  = tbl[t].inst;
      sv = n_valid[i]; sf = n_ferr[i]; sp = n_perr[i]; ss = n_strobe[i];
      send_frame(i, tbl[t].d, tbl[t].p, tbl[t].stop);
      rx[i] = 1'b1;
      repeat (50) @(negedge clk);
      check($sformatf("vec%0d_valid", t), n_valid[i] - sv, tbl[t].ev);
      check($sformatf("vec%0d_frame_err", t), n_ferr[i] - sf, tbl[t].ef);
      check($sformatf("vec%0d_parity_err", t), n_perr[i] - sp, tbl[t].ep);
      check($sformatf("vec%0d_rx_data", t), rdata(i), int'(tbl[t].ed));
      check($sformatf("vec%0d_busy", t), int'(busy[i]), 0);
      check($sformatf("vec%0d_strobes", t), n_strobe[i] - ss, (i == 1) ? 11 : 10);
      check($sformatf("vec%0d_stop_to_drop", t), fall_age[i], 1);
    end

    // Short low glitch: latency to bps_start, then false start
    sv = n_valid[0]; sf = n_ferr[0]; sp = n_perr[0];
    @(negedge clk);
    rx[0] = 1'b0;
    lat = 0;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      if (bps_start[0] && lat == 0) lat = e;
    end
    check("start_latency_edges", lat, 4);
    repeat (144) @(negedge clk);
    rx[0] = 1'b1;
    k = 0;
    while (bps_start[0] && k < 600) begin @(negedge clk); k++; end
    check("glitch_stop_timeout", int'(bps_start[0]), 0);
    dur = fall_cyc[0] - rise_cyc[0];
    check("glitch_half_bit", int'(dur >= 200 && dur <= 240), 1);
    repeat (20) @(negedge clk);
    check("glitch_busy", int'(busy[0]), 0);
    check("glitch_flags", (n_valid[0] - sv) + (n_ferr[0] - sf) + (n_perr[0] - sp), 0);
    check("glitch_rx_data", rdata(0), 8'h81);

    // Stop bit 0 followed by 20 bit-times of held-low line
    sv = n_valid[0]; sf = n_ferr[0]; sr = n_rise[0];
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    repeat (20 * BIT_CYC) @(negedge clk);
    check("break_frame_err", n_ferr[0] - sf, 1);
    check("break_valid", n_valid[0] - sv, 0);
    check("break_busy", int'(busy[0]), 1);
    check("break_bps_start", int'(bps_start[0]), 0);
    check("break_no_retrigger", n_rise[0] - sr, 1);
    rx[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("break_exit_busy", int'(busy[0]), 0);
    check("break_rx_data", rdata(0), 8'h81);
    repeat (200) @(negedge clk);
    check("break_exit_no_retrigger", n_rise[0] - sr, 1);

    // Reset during data bit 4 of 0xFF
    sv = n_valid[0]; sf = n_ferr[0]; sp = n_perr[0];
    bit_time(0, 1'b0);
    for (int b = 0; b < 4; b++) bit_time(0, 1'b1);
    repeat (200) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_bps_start", int'(bps_start[0]), 0);
    check("midrst_busy", int'(busy[0]), 0);
    check("midrst_rx_data", rdata(0), 0);
    check("midrst_flags", int'(rx_valid[0] | frame_err[0] | parity_err[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5 * BIT_CYC) @(negedge clk);
    check("midrst_no_pulse", (n_valid[0] - sv) + (n_ferr[0] - sf) + (n_perr[0] - sp), 0);
    sv = n_valid[0];
    send_frame(0, 8'h12, 1'b0, 1'b1);
    repeat (50) @(negedge clk);
    check("after_rst_valid", n_valid[0] - sv, 1);
    check("after_rst_data", rdata(0), 8'h12);

    // Back-to-back frames with no idle gap
    q0 = q_data.size();
    send_frame(0, 8'h55, 1'b0, 1'b1);
    send_frame(0, 8'hAA, 1'b0, 1'b1);
    repeat (100) @(negedge clk);
    check("b2b_count", q_data.size() - q0, 2);
    if (q_data.size() - q0 == 2) begin
      check("b2b_first", int'(q_data[q0]), 8'h55);
      check("b2b_second", int'(q_data[q0 + 1]), 8'hAA);
      check("b2b_spacing", q_cyc[q0 + 1] - q_cyc[q0], 10 * BIT_CYC);
    end
    check("b2b_busy", int'(busy[0]), 0);

    check("pulse_width_one_cycle", n_wide, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #(20 * 95000);
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive sequencer that owns the baud-rate generator's run/stop control and turns its mid-bit sample strobes into received bytes. It sits between the board's serial RX pin and the music-command decoder:
- it detects a start bit and asserts `bps_start` to run the baud generator;
- it samples `rx` on each `bps_clk` strobe and delivers an 8-bit word with status flags;
- it drops `bps_start` so the generator counter returns to 0 between frames.

## Interface
Parameters:
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even; a parity bit sits between D7 and stop when nonzero.
- `DATA_BITS`, 8: data bits per frame, LSB first; legal range 5..8.

Ports:
- `clk` in 1: single system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rx` in 1: asynchronous serial input, idle high.
- `bps_clk` in 1: one-cycle mid-bit strobe from the baud generator; first strobe comes half a bit after `bps_start` rises.
- `bps_start` out 1: run request to the baud generator; high for the whole frame.
- `rx_data` out `DATA_BITS`: last good word, held until the next good frame.
- `rx_valid` out 1: one-cycle pulse, good frame received.
- `frame_err` out 1: one-cycle pulse, stop bit sampled 0.
- `parity_err` out 1: one-cycle pulse, parity mismatch.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Input path: `rx` passes through a 2-flop synchronizer, then one history flop. `fall` = history 1 and synced 0.
- IDLE: `bps_start` = 0. On `fall`, go to START and set `bps_start` = 1.
- START: wait for `bps_clk`. Sampled 1 = false start: go to IDLE with `bps_start` = 0 and no flags. Sampled 0: go to DATA with bit counter = 0.
- DATA: each `bps_clk` shifts the synced `rx` into the MSB of the shift register, right-shifting so bits arrive LSB first. On the strobe for bit `DATA_BITS-1`, go to PARITY if `PARITY` ≠ 0, else STOP. The bit counter is 3 bits and increments only on strobes.
- PARITY: on `bps_clk`, capture the bit and compare it with the XOR of the data bits. Odd parity expects XOR(data, p) = 1; even parity expects 0.
- STOP: on `bps_clk`, drop `bps_start`.
  - Stop = 1 and parity good: load `rx_data`, pulse `rx_valid`, go to IDLE.
  - Stop = 1 and parity bad: pulse `parity_err`, `rx_data` unchanged, go to IDLE.
  - Stop = 0: pulse `frame_err` (and `parity_err` too if parity is bad), `rx_data` unchanged, go to BREAK.
- BREAK: `bps_start` = 0. Stay until synced `rx` = 1, then go to IDLE. This prevents a held-low line from retriggering.
- `bps_clk` outside START/DATA/PARITY/STOP is ignored.
- `fall` outside IDLE is ignored.

## Timing
- Reset values: `bps_start` 0, `rx_data` 0, `rx_valid` 0, `frame_err` 0, `parity_err` 0, `busy` 0. Reset also clears the state (to IDLE), shift register, counter, and synchronizer/history flops (to 1).
- Reset mid-frame: state is IDLE and `bps_start` is 0 in the cycle after reset is sampled. No pulse is emitted.
- `rx` falling at the pin to `bps_start` high: 4 rising edges (2 sync + 1 history + 1 registered output).
- Stop-bit `bps_clk` cycle to `rx_valid` / error pulse: 1 cycle, registered. `bps_start` falls on the same edge. All flag pulses are exactly 1 cycle wide.
- `bps_clk` and `fall` in the same IDLE cycle: `fall` wins; the strobe is ignored.
- The next start edge is accepted one cycle after the return to IDLE. Back-to-back frames with a 1-bit stop and no gap must be received.

## Structure
- Shared package `uart_pkg` holds:
  - state encoding (IDLE, START, DATA, PARITY, STOP, BREAK, 3 bits);
  - parity mode constants `PAR_NONE` = 0, `PAR_ODD` = 1, `PAR_EVEN` = 2.
- Sub-module `rx_sync_edge`: 2-flop synchronizer plus history flop. Outputs `rx_s` and `fall`; reset value 1.
- The baud-rate generator is external and is not instantiated here. Top level wires `bps_start` to its start input and its strobe output to `bps_clk`.

## Test plan
Bench setup: 50 MHz clock, real baud generator at 115200 (divider 433, strobe at count 216), `PARITY` = 0 unless noted.
- Send 0xA5 with 1 stop bit -> `rx_valid` pulse 1 cycle, `rx_data` = 0xA5, `bps_start` low within 1 cycle of the 10th strobe, `busy` back to 0.
- 3 µs low glitch on `rx` -> `bps_start` pulses high for about half a bit, then state is IDLE with no flags and `rx_data` unchanged.
- Send 0x3C with stop bit forced 0, then hold `rx` low for 20 bit-times -> single `frame_err` pulse, `rx_data` keeps the previous value, FSM stays in BREAK until `rx` = 1, no retrigger.
- `PARITY` = 2: send 0x07 with parity 1 -> `rx_valid`, data 0x07. Send 0x07 with parity 0 -> `parity_err` only.
- Assert `rst` for 1 cycle during data bit 4 of 0xFF -> all outputs at reset values on the next cycle. The following 0x12 frame is received correctly.
- Two frames 0x55 then 0xAA back-to-back with no idle gap -> two `rx_valid` pulses about 10 bit-times apart with the correct data.
